// File: rtl/lampfpu_square.sv
// Multi-cycle square unit for LAMP_FLOAT (1s/8e/7f): 8-cycle shift-add multiply, then one
// normalise/round cycle. Fixed 9-cycle latency from accept to the one-cycle valid pulse.
module lampfpu_square (
   input  logic       clk,
   input  logic       rst,
   input  logic       doSquare_i,
   input  logic       signum_op_i,
   input  logic [7:0] extExp_op_i,
   input  logic [7:0] extMant_op_i,
   input  logic       isInf_op_i,
   input  logic       isZero_op_i,
   input  logic       isSNAN_op_i,
   input  logic       isQNAN_op_i,
   output logic       busy_o,
   output logic       valid_o,
   output logic       s_res_o,
   output logic [7:0] e_res_o,
   output logic [6:0] f_res_o,
   output logic       isOverflow_o,
   output logic       isUnderflow_o
);

   typedef enum logic [1:0] {StIdle, StMul, StNorm} state_t;

   state_t      state_q;
   logic [7:0]  exp_q;
   logic [7:0]  mant_q;
   logic        nan_q;
   logic        inf_q;
   logic        zero_q;
   logic        sign_q;
   logic [15:0] acc_q;
   logic [2:0]  cnt_q;

   logic              norm;
   logic [7:0]        kept;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic [8:0]        m9;
   logic              carry;
   logic [7:0]        mant_rnd;
   logic signed [9:0] e10;
   logic [15:0]       addend;

   assign busy_o = (state_q != StIdle);
   assign addend = mant_q[cnt_q] ? ({8'h00, mant_q} << cnt_q) : 16'h0000;

   always_comb begin
      norm     = acc_q[15];
      kept     = norm ? acc_q[15:8] : acc_q[14:7];
      guard    = norm ? acc_q[7] : acc_q[6];
      sticky   = norm ? (|acc_q[6:0]) : (|acc_q[5:0]);
      round_up = guard & (sticky | kept[0]);
      m9       = {1'b0, kept} + {8'h00, round_up};
      carry    = m9[8];
      mant_rnd = carry ? 8'h80 : m9[7:0];
      e10      = $signed({1'b0, exp_q, 1'b0}) - 10'sd127
                 + $signed({9'b0, norm}) + $signed({9'b0, carry});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         exp_q         <= '0;
         mant_q        <= '0;
         nan_q         <= 1'b0;
         inf_q         <= 1'b0;
         zero_q        <= 1'b0;
         sign_q        <= 1'b0;
         acc_q         <= '0;
         cnt_q         <= '0;
         valid_o       <= 1'b0;
         s_res_o       <= 1'b0;
         e_res_o       <= '0;
         f_res_o       <= '0;
         isOverflow_o  <= 1'b0;
         isUnderflow_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (doSquare_i) begin
                  state_q <= StMul;
                  sign_q  <= signum_op_i;
                  exp_q   <= extExp_op_i;
                  mant_q  <= extMant_op_i;
                  nan_q   <= isSNAN_op_i | isQNAN_op_i;
                  inf_q   <= isInf_op_i;
                  zero_q  <= isZero_op_i;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            StMul: begin
               acc_q <= acc_q + addend;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_q <= StNorm;
            end
            StNorm: begin
               state_q       <= StIdle;
               valid_o       <= 1'b1;
               s_res_o       <= 1'b0;
               isOverflow_o  <= 1'b0;
               isUnderflow_o <= 1'b0;
               // Specials override the arithmetic path and never raise range flags.
               if (nan_q) begin
                  e_res_o <= 8'hFF;
                  f_res_o <= 7'h40;
               end else if (inf_q) begin
                  e_res_o <= 8'hFF;
                  f_res_o <= '0;
               end else if (zero_q) begin
                  e_res_o <= '0;
                  f_res_o <= '0;
               end else if (e10 >= 10'sd255) begin
                  e_res_o      <= 8'hFF;
                  f_res_o      <= '0;
                  isOverflow_o <= 1'b1;
               end else if (e10 <= 10'sd0) begin
                  e_res_o       <= '0;
                  f_res_o       <= '0;
                  isUnderflow_o <= 1'b1;
               end else begin
                  e_res_o <= e10[7:0];
                  f_res_o <= mant_rnd[6:0];
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
